// File: rtl/clock_divider.sv
// Integer clock divider: produces a registered divided clock and a one-cycle
// tick per output period. Counting is gated by enable; reset is synchronous.
module clock_divider #(
    parameter int DIVISOR = 2,
    parameter int WIDTH   = 28
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic enable,
    output logic clock_out,
    output logic tick
);

    // Terminal count and high-phase length, sized to the counter.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(DIVISOR - 1);
    localparam logic [WIDTH-1:0] HALF = WIDTH'(DIVISOR / 2);

    // Reject illegal parameterizations before any hardware is built.
    generate
        if (WIDTH < 1 || WIDTH > 62) begin : g_bad_width
            $fatal(1, "clock_divider: WIDTH=%0d out of supported range", WIDTH);
        end
        if (DIVISOR < 2 || 64'(DIVISOR) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_div
            $fatal(1, "clock_divider: DIVISOR=%0d illegal for WIDTH=%0d", DIVISOR, WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] cnt;
    logic             at_last;

    assign at_last = (cnt == LAST);

    // Period counter: 0..DIVISOR-1, holds while disabled.
    always_ff @(posedge clock_in) begin
        if (!reset_n)
            cnt <= '0;
        else if (enable)
            cnt <= at_last ? '0 : cnt + WIDTH'(1);
    end

    // Divided clock: high for the first floor(DIVISOR/2) counts of each period.
    always_ff @(posedge clock_in) begin
        if (!reset_n)
            clock_out <= 1'b0;
        else if (enable)
            clock_out <= (cnt < HALF);
    end

    // Tick: one pulse on the edge that wraps the counter; cleared when idle.
    always_ff @(posedge clock_in) begin
        if (!reset_n)
            tick <= 1'b0;
        else
            tick <= enable & at_last;
    end

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: five instances (DIVISOR 2,5,4,6,15) run against a
// reference model through a scoreboard, plus directed pattern checks.
module tb_clock_divider;

    localparam int NL = 5;
    localparam logic [NL-1:0][7:0] DIVS = {8'd15, 8'd6, 8'd4, 8'd5, 8'd2};

    logic          clk = 1'b0;
    logic [NL-1:0] rn, en, co, tk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [NL-1:0] co;
        logic [NL-1:0] tk;
    } exp_t;

    exp_t sb_q[$];

    int   m_cnt [NL];
    logic m_co  [NL];
    logic m_tk  [NL];

    always #10 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        clock_divider #(
            .DIVISOR(int'(DIVS[g])),
            .WIDTH  ((g == 4) ? 4 : 28)
        ) u_dut (
            .clock_in (clk),
            .reset_n  (rn[g]),
            .enable   (en[g]),
            .clock_out(co[g]),
            .tick     (tk[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model with the current inputs, push its prediction, clock
    // the DUT, then pop and compare every lane.
    task automatic cycle();
        exp_t e, p;
        for (int l = 0; l < NL; l++) begin
            int d;
            d = int'(DIVS[l]);
            if (!rn[l]) begin
                m_cnt[l] = 0; m_co[l] = 1'b0; m_tk[l] = 1'b0;
            end else if (en[l]) begin
                m_tk[l]  = (m_cnt[l] == d - 1);
                m_co[l]  = (m_cnt[l] < d / 2);
                m_cnt[l] = (m_cnt[l] == d - 1) ? 0 : m_cnt[l] + 1;
            end else begin
                m_tk[l] = 1'b0;
            end
            e.co[l] = m_co[l];
            e.tk[l] = m_tk[l];
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            p = sb_q.pop_front();
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("sb_co[%0d]", l), 32'(co[l]), 32'(p.co[l]));
                chk($sformatf("sb_tk[%0d]", l), 32'(tk[l]), 32'(p.tk[l]));
            end
        end
    endtask

    initial begin
        logic [9:0] pat5;
        logic [6:0] co4, en4, tk4;
        int   rises, last_t, guard;
        logic prev;

        pat5 = 10'b1100011000;          // MSB first: 1,1,0,0,0,1,1,0,0,0
        en4  = 7'b1000111;              // MSB first: 1,0,0,0,1,1,1
        co4  = 7'b1111100;
        tk4  = 7'b0000001;

        for (int l = 0; l < NL; l++) begin
            m_cnt[l] = 0; m_co[l] = 1'b0; m_tk[l] = 1'b0;
        end
        rn = '0;
        en = '1;
        @(negedge clk);

        // Reset dominates enable
        cycle();
        cycle();
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_tk", 32'(tk), 32'd0);

        // Free run from release: fixed patterns for DIVISOR 2, 5, 15
        rn = '1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            chk("d2_co",  32'(co[0]), 32'((i % 2) == 0));
            chk("d2_tk",  32'(tk[0]), 32'((i % 2) == 1));
            if (i < 10) begin
                chk("d5_co", 32'(co[1]), 32'(pat5[9 - i]));
                chk("d5_tk", 32'(tk[1]), 32'((i % 5) == 4));
            end
            chk("d15_co", 32'(co[4]), 32'((i % 15) < 7));
            chk("d15_tk", 32'(tk[4]), 32'((i % 15) == 14));
        end

        // DIVISOR=4: enable gap in the high phase
        rn[2] = 1'b0;
        cycle();
        rn[2] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            en[2] = en4[6 - i];
            cycle();
            chk("d4_gap_co", 32'(co[2]), 32'(co4[6 - i]));
            chk("d4_gap_tk", 32'(tk[2]), 32'(tk4[6 - i]));
        end
        en[2] = 1'b1;

        // DIVISOR=6: reset at cnt=4 aborts the period
        rn[3] = 1'b0;
        cycle();
        rn[3] = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        rn[3] = 1'b0;
        cycle();
        chk("d6_rst_co", 32'(co[3]), 32'd0);
        chk("d6_rst_tk", 32'(tk[3]), 32'd0);
        rn[3] = 1'b1;
        cycle();
        chk("d6_restart_co", 32'(co[3]), 32'd1);

        // Reset change between edges must not move outputs
        guard = 0;
        while (!m_co[0] && guard < 10) begin
            cycle();
            guard++;
        end
        chk("async_guard", 32'(m_co[0]), 32'd1);
        rn[0] = 1'b0;
        #5;
        chk("async_rst_co", 32'(co[0]), 32'(m_co[0]));
        cycle();
        rn[0] = 1'b1;

        // DIVISOR=2 free run for 1000 ns: 25 rises, 40 ns apart
        rises  = 0;
        last_t = 0;
        prev   = co[0];
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (co[0] && !prev) begin
                if (rises > 0) chk("d2_rise_gap", 32'($time) - 32'(last_t), 32'd40);
                last_t = int'($time);
                rises++;
            end
            prev = co[0];
        end
        chk("d2_rises", 32'(rises), 32'd25);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Bench watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
